adc_frame_unpacker: RTL

Consumes 4-lane × 64-bit frames from the ADC serial capture stage and buffers them as a stream of tagged 32-bit channel samples for the PMU DSP chain. Each frame holds 8 channel slots. Each slot is split into a 24-bit sample and an 8-bit status byte; the sample is sign-extended and pushed into an internal first-word-fall-through FIFO with a valid/ready output. Frames that cannot be fully buffered are dropped whole and counted, so the downstream never sees a partial frame.

---
 rtl/adc_frame_unpacker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/adc_frame_unpacker.sv
// Purpose: unpacks 4x64-bit ADC frames into 8 tagged, sign-extended 32-bit samples
//          held in a first-word-fall-through FIFO.
// Latency: the frame is latched at the end of the marker cycle t. Channel 0 is visible at t+2,
//          and one channel is written per cycle after that.
// Backpressure: SAMPLE_VALID/SAMPLE_READY on the output. A frame is admitted only when 8 entries
//          are free; otherwise the whole frame is dropped, counted and flagged.
// Ports: MCLK/RST (async, active-high); DATA_READY + DATA[3:0][63:0] from capture;
//        SAMPLE_VALID/SAMPLE_READY + SAMPLE/CHANNEL/FRAME_START to the DSP chain;
//        ERR_CLR clears the sticky OVERRUN/STATUS_ERR and the saturating DROP_COUNT.
module adc_frame_unpacker #(
    parameter int FIFO_DEPTH = 16   // power of two, >= 8
) (
    input  logic             MCLK,
    input  logic             RST,
    input  logic             DATA_READY,
    input  logic [3:0][63:0] DATA,
    input  logic             SAMPLE_READY,
    input  logic             ERR_CLR,
    output logic             SAMPLE_VALID,
    output logic [31:0]      SAMPLE,
    output logic [2:0]       CHANNEL,
    output logic             FRAME_START,
    output logic             OVERRUN,
    output logic             STATUS_ERR,
    output logic [7:0]       DROP_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, PUSH} state_t;

    state_t           state;
    logic [2:0]       idx;
    logic             drdy_q;
    logic [3:0][63:0] frame_q;

    logic [35:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             marker;
    logic             free_ok;
    logic             drop;
    logic             push;
    logic             pop;
    logic [63:0]      lane_w;
    logic [31:0]      slot;
    logic [35:0]      push_dat;

    // A frame marker is the falling edge of DATA_READY.
    assign marker  = drdy_q & ~DATA_READY;
    // Uses the count from before this cycle's update, so a same-cycle pop does not help admission.
    assign free_ok = (CW'(FIFO_DEPTH) - count) >= CW'(8);
    // A marker seen while a frame is still being pushed cannot be latched and is dropped.
    assign drop    = marker & ((state == PUSH) | ~free_ok);

    assign push    = (state == PUSH);
    assign pop     = SAMPLE_VALID & SAMPLE_READY;

    // Even channels come from the upper half of a lane word and odd channels from the lower half.
    assign lane_w   = frame_q[idx[2:1]];
    assign slot     = idx[0] ? lane_w[31:0] : lane_w[63:32];
    assign push_dat = {(idx == 3'd0), idx, {{8{slot[31]}}, slot[31:8]}};

    assign SAMPLE_VALID = (count != '0);
    assign {FRAME_START, CHANNEL, SAMPLE} = mem[rd_ptr];

    // Frame FSM and sticky error flags
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= 3'd0;
            drdy_q     <= 1'b0;
            frame_q    <= '0;
            OVERRUN    <= 1'b0;
            STATUS_ERR <= 1'b0;
            DROP_COUNT <= 8'd0;
        end else begin
            drdy_q <= DATA_READY;
            case (state)
                IDLE: begin
                    if (marker && free_ok) begin
                        frame_q <= DATA;
                        idx     <= 3'd0;
                        state   <= PUSH;
                    end
                end
                PUSH: begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A clear wins over any set that happens in the same cycle.
            if (ERR_CLR) begin
                OVERRUN    <= 1'b0;
                STATUS_ERR <= 1'b0;
                DROP_COUNT <= 8'd0;
            end else begin
                if (drop) begin
                    OVERRUN <= 1'b1;
                    if (DROP_COUNT != 8'hFF) begin
                        DROP_COUNT <= DROP_COUNT + 8'd1;
                    end
                end
                if (push && (slot[7:0] != 8'd0)) begin
                    STATUS_ERR <= 1'b1;
                end
            end
        end
    end

    // The FIFO never overflows because a frame is admitted only when 8 entries are free.
    // The storage is reset so that the head entry, and therefore the outputs, read 0 after reset.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
